// File: rtl/id_ex_elastic.sv
// ID/EX stage with valid/ready on both sides; one-cycle latency, full throughput.
// A two-entry skid buffer keeps in_ready a flop output, so out_ready never reaches decode combinationally.
module id_ex_elastic #(
   parameter int          DATA_W   = 32,
   parameter int          REG_W    = 4,
   parameter int          CTRL_W   = 12,
   parameter logic [31:0] PC_RESET = 32'hFFFFFFFF,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              stat_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] busa_in,
   input  logic [DATA_W-1:0] busb_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] bta_in,
   input  logic [REG_W-1:0]  rd_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [DATA_W-1:0] busa_out,
   output logic [DATA_W-1:0] busb_out,
   output logic [DATA_W-1:0] imm_out,
   output logic [DATA_W-1:0] pc_out,
   output logic [DATA_W-1:0] bta_out,
   output logic [REG_W-1:0]  rd_out,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [DATA_W-1:0] PC_RST = DATA_W'(PC_RESET);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] busa;
      logic [DATA_W-1:0] busb;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] bta;
      logic [REG_W-1:0]  rd;
   } beat_t;

   beat_t in_beat;
   beat_t m_q;
   beat_t s_q;
   logic  m_v;
   logic  s_v;
   logic  rdy_q;
   logic  accept;
   logic  consume;

   assign in_beat = {ctrl_in, busa_in, busb_in, imm_in, pc_in, bta_in, rd_in};
   assign accept  = in_valid && rdy_q;
   assign consume = m_v && out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q    <= '0;
         m_q.pc <= PC_RST;
         s_q    <= '0;
         m_v    <= 1'b0;
         s_v    <= 1'b0;
         rdy_q  <= 1'b1;
      end else if (flush) begin
         // Only the valid flags, control and PC are scrubbed; data fields keep stale values.
         m_v      <= 1'b0;
         s_v      <= 1'b0;
         m_q.ctrl <= '0;
         m_q.pc   <= PC_RST;
         rdy_q    <= 1'b1;
      end else if (!m_v) begin
         if (accept) begin
            m_q <= in_beat;
            m_v <= 1'b1;
         end
      end else if (!s_v) begin
         if (accept && consume) begin
            m_q <= in_beat;
         end else if (consume) begin
            m_v <= 1'b0;
         end else if (accept) begin
            s_q   <= in_beat;
            s_v   <= 1'b1;
            rdy_q <= 1'b0;
         end
      end else if (consume) begin
         m_q   <= s_q;
         s_v   <= 1'b0;
         rdy_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (stat_clr) begin
         stall_cnt <= '0;
      end else if (m_v && !out_ready && stall_cnt != {CNT_W{1'b1}}) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // Control is masked in bubbles so no stale RegWrite/MemWrite reaches execute.
   assign in_ready  = rdy_q;
   assign out_valid = m_v;
   assign ctrl_out  = m_v ? m_q.ctrl : '0;
   assign busa_out  = m_q.busa;
   assign busb_out  = m_q.busb;
   assign imm_out   = m_q.imm;
   assign pc_out    = m_q.pc;
   assign bta_out   = m_q.bta;
   assign rd_out    = m_q.rd;

endmodule

// File: tb/tb_id_ex_elastic.sv
// Bench for id_ex_elastic: directed scenarios plus randomized traffic against a queue-based model.
module tb_id_ex_elastic;
   localparam int DW = 32;
   localparam int RW = 4;
   localparam int CW = 12;
   localparam int NW = 3;
   localparam int CNT_MAX = 7;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] busa;
      logic [DW-1:0] busb;
      logic [DW-1:0] imm;
      logic [DW-1:0] pc;
      logic [DW-1:0] bta;
      logic [RW-1:0] rd;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset_n, flush, stat_clr, in_valid, in_ready, out_valid, out_ready;
   logic [CW-1:0] ctrl_out;
   logic [DW-1:0] busa_out, busb_out, imm_out, pc_out, bta_out;
   logic [RW-1:0] rd_out;
   logic [NW-1:0] stall_cnt;
   beat_t         drv;
   beat_t         obs;

   beat_t q[$];
   int    cnt_m;
   int    total;
   int    bad;

   always #5 clk = ~clk;

   id_ex_elastic #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .PC_RESET(32'hFFFFFFFF), .CNT_W(NW)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .stat_clr(stat_clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .ctrl_in(drv.ctrl), .busa_in(drv.busa), .busb_in(drv.busb), .imm_in(drv.imm),
      .pc_in(drv.pc), .bta_in(drv.bta), .rd_in(drv.rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .ctrl_out(ctrl_out), .busa_out(busa_out), .busb_out(busb_out), .imm_out(imm_out),
      .pc_out(pc_out), .bta_out(bta_out), .rd_out(rd_out), .stall_cnt(stall_cnt)
   );

   assign obs = {ctrl_out, busa_out, busb_out, imm_out, pc_out, bta_out, rd_out};

   function automatic beat_t mk(input logic [DW-1:0] pc);
      beat_t b;
      b.ctrl = CW'($urandom_range(1, 4095));
      b.busa = $urandom;
      b.busb = $urandom;
      b.imm  = $urandom;
      b.pc   = pc;
      b.bta  = $urandom;
      b.rd   = RW'($urandom);
      return b;
   endfunction

   // One clock of the reference model: a FIFO of depth two, in_ready whenever it is not full.
   task automatic tick();
      bit acc, con;
      acc = in_valid && (q.size() < 2) && !flush;
      con = out_ready && (q.size() > 0) && !flush;
      if (stat_clr) cnt_m = 0;
      else if (q.size() > 0 && !out_ready && cnt_m < CNT_MAX) cnt_m++;
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         if (con) void'(q.pop_front());
         if (acc) q.push_back(drv);
      end
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; flush = 1'b0; stat_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drv = mk(32'h0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL reset_init vld/rdy got %b/%b want 0/1", out_valid, in_ready); end
      total++; if (pc_out !== 32'hFFFFFFFF || ctrl_out !== '0) begin bad++; $display("FAIL reset_init pc/ctrl got %h/%h want ffffffff/000", pc_out, ctrl_out); end
      in_valid = 1'b1; drv = mk(32'd100); tick();
      drv = mk(32'd104); tick();
      in_valid = 1'b0; tick();
      #3 reset_n = 1'b0;
      #1;
      q.delete(); cnt_m = 0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL reset_async vld/rdy got %b/%b want 0/1", out_valid, in_ready); end
      total++; if (pc_out !== 32'hFFFFFFFF || ctrl_out !== '0 || busa_out !== '0 || rd_out !== '0) begin bad++; $display("FAIL reset_async fields pc=%h ctrl=%h busa=%h rd=%h want ffffffff/0/0/0", pc_out, ctrl_out, busa_out, rd_out); end
      total++; if (stall_cnt !== '0) begin bad++; $display("FAIL reset_async stall_cnt got %0d want 0", stall_cnt); end
      #2 reset_n = 1'b1;
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; drv = mk(DW'(i * 4)); tick();
         total++; if (out_valid !== 1'b1 || pc_out !== DW'(i * 4) || obs !== drv) begin bad++; $display("FAIL stream beat%0d vld=%b pc=%0d want 1/%0d", i, out_valid, pc_out, i * 4); end
      end
      in_valid = 1'b0; tick();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL stream_drain vld/rdy got %b/%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_skid();
      stat_clr = 1'b1; tick(); stat_clr = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin drv = mk(DW'(i * 4)); tick(); end
      out_ready = 1'b0; drv = mk(32'd12); tick();
      total++; if (in_ready !== 1'b0 || pc_out !== 32'd8) begin bad++; $display("FAIL skid_fill rdy=%b pc=%0d want 0/8", in_ready, pc_out); end
      drv = mk(32'd16);
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (in_ready !== 1'b0 || pc_out !== 32'd8 || out_valid !== 1'b1) begin bad++; $display("FAIL skid_hold%0d rdy=%b pc=%0d vld=%b want 0/8/1", i, in_ready, pc_out, out_valid); end
      end
      total++; if (stall_cnt !== 3'd3) begin bad++; $display("FAIL skid_stall_cnt got %0d want 3", stall_cnt); end
      out_ready = 1'b1; tick();
      total++; if (pc_out !== 32'd12 || in_ready !== 1'b1) begin bad++; $display("FAIL skid_rel1 pc=%0d rdy=%b want 12/1", pc_out, in_ready); end
      tick();
      total++; if (pc_out !== 32'd16 || out_valid !== 1'b1) begin bad++; $display("FAIL skid_rel2 pc=%0d vld=%b want 16/1", pc_out, out_valid); end
      in_valid = 1'b0; tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_drain vld got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      drv = mk(32'd40); tick();
      drv = mk(32'd44); tick();
      flush = 1'b1; drv = mk(32'd48); tick(); flush = 1'b0;
      total++; if (out_valid !== 1'b0 || ctrl_out !== '0 || pc_out !== 32'hFFFFFFFF || in_ready !== 1'b1) begin bad++; $display("FAIL flush_skid vld=%b ctrl=%h pc=%h rdy=%b want 0/000/ffffffff/1", out_valid, ctrl_out, pc_out, in_ready); end
      drv = mk(32'd52); tick();
      flush = 1'b1; drv = mk(32'd56); tick(); flush = 1'b0;
      total++; if (out_valid !== 1'b0 || pc_out !== 32'hFFFFFFFF) begin bad++; $display("FAIL flush_full vld=%b pc=%h want 0/ffffffff", out_valid, pc_out); end
      out_ready = 1'b1; drv = mk(32'd60); tick();
      total++; if (out_valid !== 1'b1 || obs !== drv) begin bad++; $display("FAIL flush_after vld=%b pc=%0d want 1/60", out_valid, pc_out); end
      in_valid = 1'b0; tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop vld got %b want 0 (dropped beat leaked)", out_valid); end
   endtask

   task automatic test_saturation();
      stat_clr = 1'b1; tick(); stat_clr = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1; drv = mk(32'd80); tick();
      in_valid = 1'b0;
      repeat (10) tick();
      total++; if (stall_cnt !== 3'd7) begin bad++; $display("FAIL sat_cnt got %0d want 7", stall_cnt); end
      stat_clr = 1'b1; tick(); stat_clr = 1'b0;
      total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL sat_clr got %0d want 0", stall_cnt); end
      tick();
      total++; if (stall_cnt !== 3'd1) begin bad++; $display("FAIL sat_restart got %0d want 1", stall_cnt); end
      out_ready = 1'b1; tick();
   endtask

   task automatic test_bubble_ctrl();
      out_ready = 1'b1; in_valid = 1'b1; drv = mk(32'd200); drv.ctrl = 12'hFFF; tick();
      total++; if (ctrl_out !== 12'hFFF) begin bad++; $display("FAIL bubble_live ctrl got %h want fff", ctrl_out); end
      in_valid = 1'b0; tick();
      total++; if (out_valid !== 1'b0 || ctrl_out !== '0 || pc_out !== 32'd200) begin bad++; $display("FAIL bubble_mask vld=%b ctrl=%h pc=%0d want 0/000/200", out_valid, ctrl_out, pc_out); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         stat_clr  = ($urandom_range(0, 29) == 0);
         drv = mk(DW'($urandom));
         tick();
         total++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rand%0d vld/rdy got %b/%b want %b/%b", i, out_valid, in_ready, q.size() > 0, q.size() < 2); end
         if (q.size() > 0) begin
            total++; if (obs !== q[0]) begin bad++; $display("FAIL rand%0d beat got pc=%h ctrl=%h want pc=%h ctrl=%h", i, pc_out, ctrl_out, q[0].pc, q[0].ctrl); end
         end
         total++; if (stall_cnt !== NW'(cnt_m)) begin bad++; $display("FAIL rand%0d stall_cnt got %0d want %0d", i, stall_cnt, cnt_m); end
      end
      flush = 1'b0; stat_clr = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0; cnt_m = 0;
      test_reset();
      test_stream();
      test_skid();
      test_flush();
      test_saturation();
      test_bubble_ctrl();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
